// File: rtl/proj_fm_read_sequencer.sv
// proj_fm_read_sequencer
// Read-side sequencer for the FM buffer. Arms on the write-side wrap pulse,
// accepts a start address, issues READ_ADDRESSES_COUNT single-cycle RAM reads
// and streams the returned words over valid/ready through a 2-entry skid.
//
// in_rd_data is sampled on the rising edge that closes an out_rd_en cycle, so
// a read strobed in cycle N shows up as a stream beat in cycle N+1.
//
// Optional feature macro: PROJ_FM_READER_WRAP_EN
//   defined   : read ranges crossing the buffer end wrap to address 0,
//               out_err is tied low.
//   undefined : ranges crossing the buffer end are rejected with an out_err
//               pulse; the sequencer stays idle and armed.

module proj_fm_read_sequencer #(
   parameter int FM_BUFFER_SIZE       = 16,  // proj_pkg::FM_BUFFER_SIZE
   parameter int ADDR_WIDTH           = $clog2(FM_BUFFER_SIZE),
   parameter int READ_ADDRESSES_COUNT = 4,   // proj_pkg::FM_EXTENDER_BASES_READ_COUNT
   parameter int DATA_WIDTH           = 8
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_buffer_full,
   input  logic                  in_req_valid,
   input  logic [ADDR_WIDTH-1:0] in_req_start_addr,
   output logic                  out_req_ready,
   output logic                  out_rd_en,
   output logic [ADDR_WIDTH-1:0] out_rd_addr,
   input  logic [DATA_WIDTH-1:0] in_rd_data,
   output logic                  out_data_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  in_data_ready,
   output logic                  out_done,
   output logic                  out_err
);

   localparam int CNT_W = $clog2(READ_ADDRESSES_COUNT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic                  armed;
   logic                  armed_nxt;
   logic                  req_ready_q;
   logic                  req_ready_nxt;
   logic                  rd_en_q;
   logic                  rd_en_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [ADDR_WIDTH-1:0] rd_addr_nxt;
   logic [CNT_W-1:0]      reads_left;
   logic [CNT_W-1:0]      reads_left_nxt;
   logic [CNT_W-1:0]      beats_left;
   logic [CNT_W-1:0]      beats_left_nxt;
   logic                  done_q;
   logic                  done_nxt;
   logic                  err_q;
   logic                  err_nxt;

   // skid buffer: entry 0 is the head presented on out_data
   logic [DATA_WIDTH-1:0] skid0;
   logic [DATA_WIDTH-1:0] skid0_nxt;
   logic [DATA_WIDTH-1:0] skid1;
   logic [DATA_WIDTH-1:0] skid1_nxt;
   logic [1:0]            skid_cnt;
   logic [1:0]            skid_cnt_nxt;
   logic                  valid_q;
   logic                  valid_nxt;

   logic                  push;
   logic                  pop;
   logic                  handshake;
   logic                  reject;
   logic [ADDR_WIDTH-1:0] addr_inc;

   // State and datapath registers; everything visible on the ports is a flop.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state       <= S_IDLE;
         armed       <= 1'b0;
         req_ready_q <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         reads_left  <= '0;
         beats_left  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         skid0       <= '0;
         skid1       <= '0;
         skid_cnt    <= '0;
         valid_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         armed       <= armed_nxt;
         req_ready_q <= req_ready_nxt;
         rd_en_q     <= rd_en_nxt;
         rd_addr_q   <= rd_addr_nxt;
         reads_left  <= reads_left_nxt;
         beats_left  <= beats_left_nxt;
         done_q      <= done_nxt;
         err_q       <= err_nxt;
         skid0       <= skid0_nxt;
         skid1       <= skid1_nxt;
         skid_cnt    <= skid_cnt_nxt;
         valid_q     <= valid_nxt;
      end
   end

   // Next-state, read issue, skid update, armed tracking and output flops' inputs.
   always_comb begin
      state_nxt      = state;
      rd_en_nxt      = 1'b0;
      rd_addr_nxt    = rd_addr_q;
      reads_left_nxt = reads_left;
      beats_left_nxt = beats_left;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
      skid0_nxt      = skid0;
      skid1_nxt      = skid1;

      push      = rd_en_q;               // a read issued last cycle returns now
      pop       = valid_q & in_data_ready;
      handshake = (state == S_IDLE) & req_ready_q & in_req_valid;

`ifdef PROJ_FM_READER_WRAP_EN
      reject = 1'b0;
`else
      reject = (32'(in_req_start_addr) + 32'(READ_ADDRESSES_COUNT)) > 32'(FM_BUFFER_SIZE);
`endif

      if (rd_addr_q == ADDR_WIDTH'(FM_BUFFER_SIZE - 1)) begin
         addr_inc = '0;
      end else begin
         addr_inc = rd_addr_q + 1'b1;
      end

      // skid buffer, FIFO order
      skid_cnt_nxt = skid_cnt + {1'b0, push} - {1'b0, pop};
      case (skid_cnt)
         2'd0: begin
            if (push) skid0_nxt = in_rd_data;
         end
         2'd1: begin
            if (push && pop) skid0_nxt = in_rd_data;
            else if (push)   skid1_nxt = in_rd_data;
         end
         default: begin
            if (pop) begin
               skid0_nxt = skid1;
               if (push) skid1_nxt = in_rd_data;
            end
         end
      endcase
      valid_nxt = (skid_cnt_nxt != 2'd0);

      if (pop) beats_left_nxt = beats_left - 1'b1;

      // The next read is allowed only if the data already held plus what lands
      // this edge leaves room, so occupancy + in-flight never exceeds 2.
      case (state)
         S_IDLE: begin
            if (handshake) begin
               if (reject) begin
                  err_nxt = 1'b1;
               end else begin
                  rd_en_nxt      = 1'b1;
                  rd_addr_nxt    = in_req_start_addr;
                  reads_left_nxt = CNT_W'(READ_ADDRESSES_COUNT - 1);
                  beats_left_nxt = CNT_W'(READ_ADDRESSES_COUNT);
                  state_nxt      = (READ_ADDRESSES_COUNT == 1) ? S_DRAIN : S_READ;
               end
            end
         end
         S_READ: begin
            if ((reads_left != '0) && (skid_cnt_nxt < 2'd2)) begin
               rd_en_nxt      = 1'b1;
               rd_addr_nxt    = addr_inc;
               reads_left_nxt = reads_left - 1'b1;
               if (reads_left == CNT_W'(1)) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && (beats_left == CNT_W'(1))) begin
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // armed clears in the cycle out_done is high; a coincident full pulse wins.
      armed_nxt     = in_buffer_full | (armed & ~done_q);
      req_ready_nxt = (state_nxt == S_IDLE) & armed_nxt & ~done_nxt;
   end

   assign out_req_ready  = req_ready_q;
   assign out_rd_en      = rd_en_q;
   assign out_rd_addr    = rd_addr_q;
   assign out_data_valid = valid_q;
   assign out_data       = skid0;
   assign out_done       = done_q;
`ifdef PROJ_FM_READER_WRAP_EN
   assign out_err        = 1'b0;
`else
   assign out_err        = err_q;
`endif

endmodule

// File: tb/tb_proj_fm_read_sequencer.sv
// Self-checking bench for proj_fm_read_sequencer (FM_BUFFER_SIZE=16, 4 reads).
// Reference model: on each accepted request the expected address and data
// sequences are computed from the start address; every strobe and beat is
// checked against them, together with done/err timing and skid occupancy.

module tb_proj_fm_read_sequencer;

   localparam int SIZE = 16;
   localparam int CNT  = 4;
   localparam int AW   = 4;
   localparam int DW   = 8;
`ifdef PROJ_FM_READER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_buffer_full;
   logic          in_req_valid;
   logic [AW-1:0] in_req_start_addr;
   logic          out_req_ready;
   logic          out_rd_en;
   logic [AW-1:0] out_rd_addr;
   logic [DW-1:0] in_rd_data;
   logic          out_data_valid;
   logic [DW-1:0] out_data;
   logic          in_data_ready;
   logic          out_done;
   logic          out_err;

   logic [DW-1:0] mem [SIZE];
   logic [DW-1:0] garbage;

   always #5 clk = ~clk;

   assign in_rd_data = out_rd_en ? mem[out_rd_addr] : garbage;

   proj_fm_read_sequencer #(
      .FM_BUFFER_SIZE(SIZE),
      .READ_ADDRESSES_COUNT(CNT),
      .DATA_WIDTH(DW)
   ) dut (
      .in_clk(clk),
      .in_rst(rst),
      .in_buffer_full(in_buffer_full),
      .in_req_valid(in_req_valid),
      .in_req_start_addr(in_req_start_addr),
      .out_req_ready(out_req_ready),
      .out_rd_en(out_rd_en),
      .out_rd_addr(out_rd_addr),
      .in_rd_data(in_rd_data),
      .out_data_valid(out_data_valid),
      .out_data(out_data),
      .in_data_ready(in_data_ready),
      .out_done(out_done),
      .out_err(out_err)
   );

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [AW-1:0] q_addr [$];
   logic [DW-1:0] q_data [$];
   bit exp_done = 1'b0;
   bit exp_err  = 1'b0;
   bit last_reject = 1'b0;
   int occ = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int first_rd = -1;
   int first_beat = -1;
   int done_cyc = 0;
   int beats = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check the current cycle against the model, then advance one clock.
   task automatic tick();
      bit hs;
      bit acc;
      bit done_n;
      bit err_n;
      logic [AW-1:0] a;
      hs     = in_req_valid && out_req_ready;
      acc    = out_data_valid && in_data_ready;
      done_n = 1'b0;
      err_n  = 1'b0;
      chk("done", 32'(out_done), 32'(exp_done));
      chk("err", 32'(out_err), 32'(exp_err));
      chk("occupancy_le_2", 32'((occ + int'(out_rd_en)) <= 2), 32'd1);
      if (out_done) done_cyc = cyc;
      if (out_rd_en) begin
         if (q_addr.size() == 0) chk("read_without_request", 32'(out_rd_en), 32'd0);
         else begin
            chk("rd_addr", 32'(out_rd_addr), 32'(q_addr.pop_front()));
            if (first_rd < 0) first_rd = cyc;
         end
      end
      if (acc) begin
         if (q_data.size() == 0) chk("beat_without_request", 32'(acc), 32'd0);
         else begin
            chk("data", 32'(out_data), 32'(q_data.pop_front()));
            beats++;
            if (first_beat < 0) first_beat = cyc;
            if (q_data.size() == 0) done_n = 1'b1;
         end
      end
      occ = occ + int'(out_rd_en) - int'(acc);
      if (hs) begin
         hs_cyc = cyc; first_rd = -1; first_beat = -1; beats = 0;
         if (WRAP || (int'(in_req_start_addr) + CNT <= SIZE)) begin
            last_reject = 1'b0;
            for (int i = 0; i < CNT; i++) begin
               a = AW'((int'(in_req_start_addr) + i) % SIZE);
               q_addr.push_back(a);
               q_data.push_back(mem[a]);
            end
         end else begin
            last_reject = 1'b1;
            err_n = 1'b1;
         end
      end
      exp_done = done_n;
      exp_err  = err_n;
      @(posedge clk);
      #1;
      cyc++;
      garbage = DW'($urandom);
   endtask

   task automatic set_ready(input int mode, input int k);
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      case (mode)
         0:       in_data_ready = 1'b1;
         1:       in_data_ready = pat[k % 6];
         default: in_data_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic arm();
      in_buffer_full = 1'b1;
      tick();
      in_buffer_full = 1'b0;
      chk("ready_after_full", 32'(out_req_ready), 32'd1);
   endtask

   task automatic run_req(input int start, input int mode, input bit bf_on_done);
      bit got;
      int k;
      got = 1'b0;
      in_req_start_addr = AW'(start);
      in_req_valid = 1'b1;
      for (k = 0; k < 20 && !got; k++) begin
         got = out_req_ready;
         set_ready(mode, k);
         tick();
      end
      in_req_valid = 1'b0;
      chk("req_accepted", 32'(got), 32'd1);
      if (!got) return;
      if (last_reject) begin
         chk("ready_after_reject", 32'(out_req_ready), 32'd1);
         repeat (4) tick();
         return;
      end
      for (k = 0; k < 100; k++) begin
         set_ready(mode, k);
         if (out_done) break;
         tick();
      end
      chk("done_seen", 32'(out_done), 32'd1);
      chk("ready_in_done_cycle", 32'(out_req_ready), 32'd0);
      if (bf_on_done) in_buffer_full = 1'b1;
      tick();
      in_buffer_full = 1'b0;
      if (bf_on_done) chk("ready_after_coincident_full", 32'(out_req_ready), 32'd1);
      chk("beats", 32'(beats), 32'(CNT));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(out_req_ready), 32'd0);
      chk({tag, "_rd_en"}, 32'(out_rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(out_rd_addr), 32'd0);
      chk({tag, "_data_valid"}, 32'(out_data_valid), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_done"}, 32'(out_done), 32'd0);
      chk({tag, "_err"}, 32'(out_err), 32'd0);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      in_buffer_full = 1'b0;
      in_req_valid = 1'b0;
      in_req_start_addr = '0;
      in_data_ready = 1'b0;
      garbage = '0;
      for (int i = 0; i < SIZE; i++) mem[i] = DW'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      // request while unarmed: never accepted, no reads
      in_req_valid = 1'b1;
      in_req_start_addr = 4'd5;
      repeat (5) begin
         chk("ready_unarmed", 32'(out_req_ready), 32'd0);
         tick();
      end
      in_req_valid = 1'b0;
      arm();

      // start=3, ready held high: exact latency
      run_req(3, 0, 1'b0);
      chk("lat_first_read", 32'(first_rd - hs_cyc), 32'd1);
      chk("lat_first_beat", 32'(first_beat - hs_cyc), 32'd2);
      chk("lat_done", 32'(done_cyc - hs_cyc), 32'd6);

      // start=14: wraps or is rejected depending on the build
      arm();
      run_req(14, 0, 1'b0);
      chk("start14_reject_flag", 32'(last_reject), 32'(!WRAP));

      // ready toggling 1,0,0,1,0,1...
      arm();
      run_req(1, 1, 1'b0);

      // full pulse coincident with done keeps the sequencer armed
      arm();
      run_req(2, 0, 1'b1);
      run_req(7, 0, 1'b0);

      // randomized requests and backpressure
      for (int n = 0; n < 24; n++) begin
         arm();
         run_req(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(0, 2)), 1'b0);
      end

      // reset while draining
      arm();
      in_req_valid = 1'b1;
      in_req_start_addr = 4'd4;
      in_data_ready = 1'b1;
      tick();
      in_req_valid = 1'b0;
      k = 0;
      while (beats < 2 && k < 20) begin
         tick();
         k++;
      end
      in_data_ready = 1'b0;
      repeat (3) tick();
      chk("drain_reads_all_issued", 32'(q_addr.size()), 32'd0);
      chk("drain_valid", 32'(out_data_valid), 32'(occ > 0));
      #2 rst = 1'b1;
      #1;
      chk_all_zero("async_reset");
      q_addr.delete();
      q_data.delete();
      occ = 0;
      exp_done = 1'b0;
      exp_err = 1'b0;
      @(posedge clk);
      #1;
      chk("done_in_reset", 32'(out_done), 32'd0);
      rst = 1'b0;
      repeat (4) begin
         chk("ready_after_reset", 32'(out_req_ready), 32'd0);
         tick();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
